// File: rtl/seg_scan_driver_if.sv
// Display bus between the countdown source and the multiplexed 7-segment driver.
// The master side supplies the BCD word and blink request; the slave side
// (the scan driver) returns segment/anode drives and the frame latch pulse.
interface seg_scan_driver_if;
    logic [7:0] bcd_in;
    logic       blink_req;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic       frame_tick;

    modport master (
        output bcd_in,
        output blink_req,
        input  seg_n,
        input  an_n,
        input  frame_tick
    );

    modport slave (
        input  bcd_in,
        input  blink_req,
        output seg_n,
        output an_n,
        output frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment scan driver.
// Cycles tens digit -> gap -> units digit -> gap, latching the BCD word once
// per frame so a frame never shows a half-updated count. Supports leading
// zero suppression on the tens digit and a frame-based blink.
module seg_scan_driver #(
    parameter int       SCAN_DIV     = 1000,
    parameter int       GAP_CYC      = 16,
    parameter int       BLINK_FRAMES = 64,
    parameter bit       LZS          = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_driver_if.slave bus
);

    // Prescaler only needs to reach the longer of the two slot lengths minus one.
    localparam int MAX_SLOT = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int PW       = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;
    localparam int BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] DIG_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        DIG1 = 2'd0,
        GAP0 = 2'd1,
        DIG0 = 2'd2,
        GAP1 = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic [7:0]      latch;
    logic [BW-1:0]   blink_cnt;
    logic            blink_ph;

    logic            slot_last;
    logic            frame_event;
    logic [6:0]      tens_seg;
    logic [6:0]      units_seg;

    logic [6:0]      seg_q;
    logic [1:0]      an_q;
    logic            tick_q;

    // Active-low gfedcba pattern for one nibble; A..E read as a dash, F as blank.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hF:    s = SEG_BLANK;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Slot-end detection and segment patterns for the latched word.
    always_comb begin
        slot_last = 1'b0;
        if (state == DIG1 || state == DIG0) begin
            slot_last = (prescaler == DIG_LAST);
        end else begin
            slot_last = (prescaler == GAP_LAST);
        end
        frame_event = (state == GAP1) && slot_last;

        tens_seg = decode(latch[7:4]);
        if (LZS && (latch[7:4] == 4'h0)) begin
            tens_seg = SEG_BLANK;
        end
        units_seg = decode(latch[3:0]);
    end

    // Scan FSM, frame latch, blink phase and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= GAP1;
            prescaler <= '0;
            latch     <= 8'hFF;
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
            seg_q     <= SEG_BLANK;
            an_q      <= 2'b11;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;

            if (slot_last) begin
                prescaler <= '0;
                case (state)
                    DIG1:    state <= GAP0;
                    GAP0:    state <= DIG0;
                    DIG0:    state <= GAP1;
                    default: begin
                        state  <= DIG1;
                        latch  <= bus.bcd_in;
                        tick_q <= 1'b1;
                    end
                endcase
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            if (!bus.blink_req) begin
                blink_cnt <= '0;
                blink_ph  <= 1'b1;
            end else if (frame_event) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            case (state)
                DIG1: begin
                    an_q  <= 2'b01;
                    seg_q <= tens_seg;
                end
                DIG0: begin
                    an_q  <= 2'b10;
                    seg_q <= units_seg;
                end
                default: begin
                    an_q  <= 2'b11;
                    seg_q <= SEG_BLANK;
                end
            endcase

            if (bus.blink_req && !blink_ph) begin
                an_q <= 2'b11;
            end
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.an_n       = an_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with short scan timing
// (SCAN_DIV=4, GAP_CYC=2, BLINK_FRAMES=2, LZS=1, frame = 12 cycles).
module tb_seg_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passes = 0;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .SCAN_DIV     (4),
        .GAP_CYC      (2),
        .BLINK_FRAMES (2),
        .LZS          (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_tick is seen, bounded so the bench never hangs.
    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.frame_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Expected anode drive k cycles after a frame_tick sample.
    function automatic logic [1:0] exp_an(input int k, input bit dark);
        if (dark)             return 2'b11;
        if (k >= 1 && k <= 4) return 2'b01;
        if (k >= 7 && k <= 10) return 2'b10;
        return 2'b11;
    endfunction

    // Expected segment drive k cycles after a frame_tick sample.
    function automatic logic [6:0] exp_seg(input int k, input logic [6:0] ts, input logic [6:0] us);
        if (k >= 1 && k <= 4)  return ts;
        if (k >= 7 && k <= 10) return us;
        return 7'h7F;
    endfunction

    task automatic test_reset();
        bit found;
        bus.bcd_in    = 8'h27;
        bus.blink_req = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (bus.an_n !== 2'b11 || bus.seg_n !== 7'h7F || bus.frame_tick !== 1'b0)
            $display("[TB] FAIL reset_outputs got an=%b seg=%h tick=%b exp an=11 seg=7f tick=0",
                     bus.an_n, bus.seg_n, bus.frame_tick);
        else passes++;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.frame_tick !== 1'b0)
            $display("[TB] FAIL reset_tick_early got=%b exp=0", bus.frame_tick);
        else passes++;
        step();
        checks++;
        if (bus.frame_tick !== 1'b1)
            $display("[TB] FAIL reset_first_tick got=%b exp=1", bus.frame_tick);
        else passes++;

        // Walk into the units slot, then reset mid-digit.
        for (int k = 1; k <= 8; k++) step();
        checks++;
        if (bus.an_n !== 2'b10 || bus.seg_n !== 7'h78)
            $display("[TB] FAIL reset_pre_dig0 got an=%b seg=%h exp an=10 seg=78", bus.an_n, bus.seg_n);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.an_n !== 2'b11 || bus.seg_n !== 7'h7F || bus.frame_tick !== 1'b0)
            $display("[TB] FAIL reset_mid_frame got an=%b seg=%h tick=%b exp an=11 seg=7f tick=0",
                     bus.an_n, bus.seg_n, bus.frame_tick);
        else passes++;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.frame_tick !== 1'b0 || bus.an_n !== 2'b11)
            $display("[TB] FAIL reset_rel_gap got tick=%b an=%b exp tick=0 an=11", bus.frame_tick, bus.an_n);
        else passes++;
        step();
        checks++;
        if (bus.frame_tick !== 1'b1)
            $display("[TB] FAIL reset_rel_tick got=%b exp=1", bus.frame_tick);
        else passes++;
        wait_tick(found);
        checks++;
        if (found !== 1'b1) $display("[TB] FAIL reset_resync got=%b exp=1", found);
        else passes++;
    endtask

    task automatic test_digits();
        bit found;
        bus.bcd_in = 8'h27;
        wait_tick(found);
        checks++;
        if (found !== 1'b1) $display("[TB] FAIL digits_sync got=%b exp=1", found);
        else passes++;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (bus.an_n !== exp_an(k, 1'b0) || bus.seg_n !== exp_seg(k, 7'h24, 7'h78))
                $display("[TB] FAIL digits_27 k=%0d got an=%b seg=%h exp an=%b seg=%h",
                         k, bus.an_n, bus.seg_n, exp_an(k, 1'b0), exp_seg(k, 7'h24, 7'h78));
            else passes++;
            checks++;
            if (bus.frame_tick !== (k == 12))
                $display("[TB] FAIL digits_tick k=%0d got=%b exp=%b", k, bus.frame_tick, (k == 12));
            else passes++;
        end
    endtask

    task automatic test_decode();
        logic [7:0] words [7]  = '{8'h05, 8'hFF, 8'h0A, 8'h9E, 8'hB8, 8'h61, 8'h34};
        logic [6:0] tens  [7]  = '{7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h3F, 7'h02, 7'h30};
        logic [6:0] units [7]  = '{7'h12, 7'h7F, 7'h3F, 7'h3F, 7'h00, 7'h79, 7'h19};
        for (int w = 0; w < 7; w++) begin
            // Sitting on a frame_tick sample: the word set now shows in the next frame.
            bus.bcd_in = words[w];
            for (int k = 1; k <= 12; k++) step();
            for (int k = 1; k <= 12; k++) begin
                step();
                if (k == 2 || k == 8) begin
                    checks++;
                    if (bus.an_n !== exp_an(k, 1'b0) || bus.seg_n !== exp_seg(k, tens[w], units[w]))
                        $display("[TB] FAIL decode_%h k=%0d got an=%b seg=%h exp an=%b seg=%h",
                                 words[w], k, bus.an_n, bus.seg_n, exp_an(k, 1'b0),
                                 exp_seg(k, tens[w], units[w]));
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_tearing();
        bit found;
        bus.bcd_in = 8'h27;
        wait_tick(found);
        for (int k = 1; k <= 12; k++) step();
        checks++;
        if (found !== 1'b1 || bus.frame_tick !== 1'b1)
            $display("[TB] FAIL tearing_sync got found=%b tick=%b exp 1 1", found, bus.frame_tick);
        else passes++;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (bus.an_n !== exp_an(k, 1'b0) || bus.seg_n !== exp_seg(k, 7'h24, 7'h78))
                $display("[TB] FAIL tearing_old k=%0d got an=%b seg=%h exp an=%b seg=%h",
                         k, bus.an_n, bus.seg_n, exp_an(k, 1'b0), exp_seg(k, 7'h24, 7'h78));
            else passes++;
            if (k == 1) bus.bcd_in = 8'h31;
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (bus.an_n !== exp_an(k, 1'b0) || bus.seg_n !== exp_seg(k, 7'h30, 7'h79))
                $display("[TB] FAIL tearing_new k=%0d got an=%b seg=%h exp an=%b seg=%h",
                         k, bus.an_n, bus.seg_n, exp_an(k, 1'b0), exp_seg(k, 7'h30, 7'h79));
            else passes++;
        end
    endtask

    task automatic test_blink();
        bit found;
        bus.bcd_in = 8'h27;
        wait_tick(found);
        checks++;
        if (found !== 1'b1) $display("[TB] FAIL blink_sync got=%b exp=1", found);
        else passes++;
        bus.blink_req = 1'b1;
        // Two visible frames, then two dark frames, then visible again.
        for (int f = 0; f < 5; f++) begin
            for (int k = 1; k <= 12; k++) begin
                step();
                checks++;
                if (bus.an_n !== exp_an(k, (f == 2 || f == 3)))
                    $display("[TB] FAIL blink_cycle f=%0d k=%0d got=%b exp=%b",
                             f, k, bus.an_n, exp_an(k, (f == 2 || f == 3)));
                else passes++;
            end
        end
        // Frames 5 visible, 6 dark: drop the request partway through the dark frame.
        for (int k = 1; k <= 12; k++) step();
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (bus.an_n !== exp_an(k, (k <= 3)))
                $display("[TB] FAIL blink_drop k=%0d got=%b exp=%b", k, bus.an_n, exp_an(k, (k <= 3)));
            else passes++;
            if (k == 3) bus.blink_req = 1'b0;
        end
        // Re-assert: a full visible half-period must come first.
        bus.blink_req = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 1; k <= 12; k++) begin
                step();
                checks++;
                if (bus.an_n !== exp_an(k, (f == 2)))
                    $display("[TB] FAIL blink_restart f=%0d k=%0d got=%b exp=%b",
                             f, k, bus.an_n, exp_an(k, (f == 2)));
                else passes++;
            end
        end
        bus.blink_req = 1'b0;
    endtask

    initial begin
        bus.bcd_in    = 8'hFF;
        bus.blink_req = 1'b0;
        $display("[TB] starting seg_scan_driver bench");
        test_reset();
        test_digits();
        test_decode();
        test_tearing();
        test_blink();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
